// File: rtl/alu_cnt_dec_unit_pkg.sv
// Shared constants for the ALU / decoder / counter utility block.
package alu_cnt_dec_unit_pkg;

   localparam int ALU_OP_W = 3;

   localparam logic [ALU_OP_W-1:0] ALU_ADD = 3'b000;
   localparam logic [ALU_OP_W-1:0] ALU_SUB = 3'b001;
   localparam logic [ALU_OP_W-1:0] ALU_NOT = 3'b010;
   localparam logic [ALU_OP_W-1:0] ALU_AND = 3'b011;
   localparam logic [ALU_OP_W-1:0] ALU_OR  = 3'b100;
   localparam logic [ALU_OP_W-1:0] ALU_XOR = 3'b101;
   localparam logic [ALU_OP_W-1:0] ALU_SLT = 3'b110;
   localparam logic [ALU_OP_W-1:0] ALU_EQ  = 3'b111;

endpackage

// File: rtl/alu_cnt_dec_unit_alu4_core.sv
// Combinational 4-bit ALU with zero, signed-overflow and carry flags.
module alu4_core
   import alu_cnt_dec_unit_pkg::*;
(
   input  logic [ALU_OP_W-1:0] fnselec,
   input  logic [3:0]          a,
   input  logic [3:0]          b,
   output logic [3:0]          res,
   output logic                zero,
   output logic                overflow,
   output logic                carry
);

   logic [4:0] add_sum_s;
   logic [4:0] sub_sum_s;
   logic       add_ovf_s;
   logic       sub_ovf_s;

   // Subtraction is a + ~b + 1, so its carry-out means "no borrow".
   assign add_sum_s = {1'b0, a} + {1'b0, b};
   assign sub_sum_s = {1'b0, a} + {1'b0, ~b} + 5'd1;
   assign add_ovf_s = (a[3] == b[3]) && (add_sum_s[3] != a[3]);
   assign sub_ovf_s = (a[3] != b[3]) && (sub_sum_s[3] != a[3]);

   // Operation select; flags other than zero are only meaningful for ADD/SUB.
   always_comb begin
      res      = 4'h0;
      overflow = 1'b0;
      carry    = 1'b0;
      case (fnselec)
         ALU_ADD: begin
            res      = add_sum_s[3:0];
            carry    = add_sum_s[4];
            overflow = add_ovf_s;
         end
         ALU_SUB: begin
            res      = sub_sum_s[3:0];
            carry    = sub_sum_s[4];
            overflow = sub_ovf_s;
         end
         ALU_NOT: res = ~a;
         ALU_AND: res = a & b;
         ALU_OR:  res = a | b;
         ALU_XOR: res = a ^ b;
         ALU_SLT: res = {3'b000, sub_sum_s[3] ^ sub_ovf_s};
         ALU_EQ:  res = {3'b000, (a == b)};
         default: res = 4'h0;
      endcase
   end

   assign zero = (res == 4'h0);

endmodule

// File: rtl/alu_cnt_dec_unit.sv
// Utility datapath: 4-bit ALU, 3-to-8 one-hot decoder and a tick-driven down counter.
module alu_cnt_dec_unit
   import alu_cnt_dec_unit_pkg::*;
#(
   parameter int                CNT_W   = 3,
   parameter logic [CNT_W-1:0]  CNT_RST = 3'd7
)(
   input  logic                clk,
   input  logic                rst,
   input  logic [ALU_OP_W-1:0] alu_fnselec,
   input  logic [3:0]          alu_a,
   input  logic [3:0]          alu_b,
   output logic [3:0]          alu_res,
   output logic                alu_zero,
   output logic                alu_overflow,
   output logic                alu_carry,
   input  logic [2:0]          dec_x,
   input  logic                dec_en,
   output logic [7:0]          dec_y,
   input  logic                cnt_tick,
   input  logic                cnt_en,
   output logic [CNT_W-1:0]    cnt_q
);

   logic [7:0]       dec_y_s;
   logic [CNT_W-1:0] cnt_r;

   alu4_core u_alu (
      .fnselec  (alu_fnselec),
      .a        (alu_a),
      .b        (alu_b),
      .res      (alu_res),
      .zero     (alu_zero),
      .overflow (alu_overflow),
      .carry    (alu_carry)
   );

   // One-hot decode, all zeros when disabled.
   always_comb begin
      dec_y_s = 8'h00;
      if (dec_en) begin
         dec_y_s = 8'h01 << dec_x;
      end else begin
         dec_y_s = 8'h00;
      end
   end

   assign dec_y = dec_y_s;

   // Down counter; reset dominates, wraps from zero back to the reset value.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= CNT_RST;
      end else if (cnt_en && cnt_tick) begin
         if (cnt_r == {CNT_W{1'b0}}) begin
            cnt_r <= CNT_RST;
         end else begin
            cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign cnt_q = cnt_r;

endmodule

// File: tb/tb_alu_cnt_dec_unit.sv
// Self-checking bench: directed edge cases plus randomized stimulus against an arithmetic reference model.
module tb_alu_cnt_dec_unit;
   import alu_cnt_dec_unit_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] alu_fnselec;
   logic [3:0] alu_a, alu_b, alu_res;
   logic       alu_zero, alu_overflow, alu_carry;
   logic [2:0] dec_x;
   logic       dec_en;
   logic [7:0] dec_y;
   logic       cnt_tick, cnt_en;
   logic [2:0] cnt_q;

   int n_checks = 0;
   int n_errors = 0;
   int cnt_m    = 7;

   alu_cnt_dec_unit dut (
      .clk          (clk),
      .rst          (rst),
      .alu_fnselec  (alu_fnselec),
      .alu_a        (alu_a),
      .alu_b        (alu_b),
      .alu_res      (alu_res),
      .alu_zero     (alu_zero),
      .alu_overflow (alu_overflow),
      .alu_carry    (alu_carry),
      .dec_x        (dec_x),
      .dec_en       (dec_en),
      .dec_y        (dec_y),
      .cnt_tick     (cnt_tick),
      .cnt_en       (cnt_en),
      .cnt_q        (cnt_q)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference ALU from signed/unsigned integer arithmetic: {zero, ovf, carry, res[3:0]}
   function automatic logic [6:0] ref_alu(input int op, input int a, input int b);
      int sa, sb, r, c, v;
      sa = (a > 7) ? a - 16 : a;
      sb = (b > 7) ? b - 16 : b;
      c = 0;
      v = 0;
      case (op)
         0: begin r = a + b;      c = (r > 15) ? 1 : 0; v = ((sa + sb) > 7 || (sa + sb) < -8) ? 1 : 0; end
         1: begin r = a - b + 16; c = (a >= b) ? 1 : 0; v = ((sa - sb) > 7 || (sa - sb) < -8) ? 1 : 0; end
         2: r = 15 - a;
         3: r = a & b;
         4: r = a | b;
         5: r = a ^ b;
         6: r = (sa < sb) ? 1 : 0;
         7: r = (a == b) ? 1 : 0;
         default: r = 0;
      endcase
      r = r % 16;
      return {((r == 0) ? 1'b1 : 1'b0), v[0], c[0], r[3:0]};
   endfunction

   task automatic alu_case(input string tag, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] e_res, input logic e_z, input logic e_o, input logic e_c);
      alu_fnselec = op;
      alu_a       = a;
      alu_b       = b;
      #1;
      check_val({tag, ".res"}, 32'(alu_res), 32'(e_res));
      check_val({tag, ".zero"}, 32'(alu_zero), 32'(e_z));
      check_val({tag, ".ovf"}, 32'(alu_overflow), 32'(e_o));
      check_val({tag, ".carry"}, 32'(alu_carry), 32'(e_c));
   endtask

   // Drive counter controls for one cycle, advance model, sample after the edge.
   task automatic step(input logic r, input logic en, input logic tk);
      @(negedge clk);
      rst      = r;
      cnt_en   = en;
      cnt_tick = tk;
      @(posedge clk);
      if (r) cnt_m = 7;
      else if (en && tk) cnt_m = (cnt_m == 0) ? 7 : cnt_m - 1;
      #1;
   endtask

   initial begin
      int exp_seq[8] = '{6, 5, 4, 3, 2, 1, 0, 7};
      logic [6:0] m;
      rst = 1'b1; alu_fnselec = 3'd0; alu_a = 4'h0; alu_b = 4'h0;
      dec_x = 3'd0; dec_en = 1'b0; cnt_tick = 1'b0; cnt_en = 1'b0;

      step(1'b1, 1'b0, 1'b0);
      check_val("cnt_reset", 32'(cnt_q), 32'd7);

      alu_case("add_7p1", ALU_ADD, 4'h7, 4'h1, 4'h8, 1'b0, 1'b1, 1'b0);
      alu_case("add_Fp1", ALU_ADD, 4'hF, 4'h1, 4'h0, 1'b1, 1'b0, 1'b1);
      alu_case("sub_0m1", ALU_SUB, 4'h0, 4'h1, 4'hF, 1'b0, 1'b0, 1'b0);
      alu_case("sub_8m1", ALU_SUB, 4'h8, 4'h1, 4'h7, 1'b0, 1'b1, 1'b1);
      alu_case("sub_5m5", ALU_SUB, 4'h5, 4'h5, 4'h0, 1'b1, 1'b0, 1'b1);
      alu_case("slt_F_1", ALU_SLT, 4'hF, 4'h1, 4'h1, 1'b0, 1'b0, 1'b0);
      alu_case("slt_1_F", ALU_SLT, 4'h1, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0);
      alu_case("eq_A_A",  ALU_EQ,  4'hA, 4'hA, 4'h1, 1'b0, 1'b0, 1'b0);
      alu_case("and_CA",  ALU_AND, 4'hC, 4'hA, 4'h8, 1'b0, 1'b0, 1'b0);
      alu_case("or_CA",   ALU_OR,  4'hC, 4'hA, 4'hE, 1'b0, 1'b0, 1'b0);
      alu_case("xor_CA",  ALU_XOR, 4'hC, 4'hA, 4'h6, 1'b0, 1'b0, 1'b0);
      alu_case("not_C",   ALU_NOT, 4'hC, 4'hA, 4'h3, 1'b0, 1'b0, 1'b0);

      dec_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         dec_x = 3'(i);
         #1;
         check_val($sformatf("dec_sweep%0d", i), 32'(dec_y), 32'(1 << i));
      end
      dec_x = 3'd5; dec_en = 1'b0;
      #1;
      check_val("dec_disabled", 32'(dec_y), 32'h00);

      step(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b1, 1'b1);
         check_val($sformatf("cnt_tick%0d", i), 32'(cnt_q), 32'(exp_seq[i]));
         step(1'b0, 1'b1, 1'b0);
         check_val($sformatf("cnt_gap%0d", i), 32'(cnt_q), 32'(exp_seq[i]));
      end
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      check_val("cnt_hold_dis", 32'(cnt_q), 32'd7);
      step(1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b1, 1'b1);
      check_val("cnt_at3", 32'(cnt_q), 32'd3);
      step(1'b1, 1'b1, 1'b1);
      check_val("cnt_rst_tick", 32'(cnt_q), 32'd7);

      // Randomized: all three functions exercised together every cycle.
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         alu_fnselec = 3'($urandom_range(7, 0));
         alu_a       = 4'($urandom_range(15, 0));
         alu_b       = 4'($urandom_range(15, 0));
         dec_x       = 3'($urandom_range(7, 0));
         dec_en      = 1'($urandom_range(1, 0));
         rst         = ($urandom_range(19, 0) == 0);
         cnt_en      = ($urandom_range(3, 0) != 0);
         cnt_tick    = ($urandom_range(2, 0) != 0);
         #1;
         m = ref_alu(int'(alu_fnselec), int'(alu_a), int'(alu_b));
         check_val("rnd_alu_res", 32'(alu_res), 32'(m[3:0]));
         check_val("rnd_alu_flags", {29'd0, alu_zero, alu_overflow, alu_carry}, {29'd0, m[6:4]});
         check_val("rnd_dec", 32'(dec_y), dec_en ? 32'(1 << int'(dec_x)) : 32'h0);
         @(posedge clk);
         if (rst) cnt_m = 7;
         else if (cnt_en && cnt_tick) cnt_m = (cnt_m == 0) ? 7 : cnt_m - 1;
         #1;
         check_val("rnd_cnt", 32'(cnt_q), 32'(cnt_m));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
